// File: rtl/p_hit_pkg.sv
// rtl/p_hit_pkg.sv - shared types and constants for the p_hit_1 dispatch block
package p_hit_pkg;
   localparam int D_BITS_DEF   = 32;
   localparam int Q_BITS       = 16;
   localparam int IDX_BITS_DEF = 16;
   localparam int NUM_PORTS    = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/p_hit_dispatch_port.sv
// rtl/p_hit_dispatch_port.sv - one downstream port: pending flag and write strobe
module p_hit_dispatch_port (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic full,
   output logic wr_en,
   output logic pending
);
   logic r_pend;

   // A load in the same cycle as the final write re-arms the flag for the next beat
   always_ff @(posedge clock) begin
      if (reset)
         r_pend <= 1'b0;
      else if (load)
         r_pend <= 1'b1;
      else if (wr_en)
         r_pend <= 1'b0;
   end

   assign wr_en   = r_pend & ~full & ~reset;
   assign pending = r_pend;
endmodule

// File: rtl/p_hit_dispatch.sv
// rtl/p_hit_dispatch.sv - ray/triangle dispatch into p_hit_1; P_HIT_DISPATCH_STATS_EN adds stall_cycles
module p_hit_dispatch
   import p_hit_pkg::*;
#(
   parameter int D_BITS   = D_BITS_DEF,
   parameter int IDX_BITS = IDX_BITS_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [3*D_BITS-1:0]     ray_origin,
   input  logic [3*D_BITS-1:0]     ray_dir,
   input  logic [IDX_BITS-1:0]     ray_num_tris,
   input  logic                    ray_empty,
   output logic                    ray_rd_en,
   input  logic [3*D_BITS-1:0]     tri_normal,
   input  logic [3*D_BITS-1:0]     tri_v0,
   input  logic                    tri_empty,
   output logic                    tri_rd_en,
   output logic [3*D_BITS-1:0]     tri_normal_1,
   output logic [3*D_BITS-1:0]     v0,
   output logic [3*D_BITS-1:0]     origin,
   output logic [3*D_BITS-1:0]     tri_normal_2,
   output logic [3*D_BITS-1:0]     dir,
   output logic [NUM_PORTS-1:0]    in_wr_en,
   input  logic [NUM_PORTS-1:0]    in_full,
   output logic [IDX_BITS-1:0]     tri_idx,
   output logic                    busy,
   output logic                    done
`ifdef P_HIT_DISPATCH_STATS_EN
   ,
   output logic [31:0]             stall_cycles
`endif
);
   state_t                 r_state;
   state_t                 w_next;
   logic [3*D_BITS-1:0]    r_origin;
   logic [3*D_BITS-1:0]    r_dir;
   logic [3*D_BITS-1:0]    r_normal;
   logic [3*D_BITS-1:0]    r_v0;
   logic [IDX_BITS-1:0]    r_num_tris;
   logic [IDX_BITS-1:0]    r_tri_idx;
   logic [NUM_PORTS-1:0]   w_pend;
   logic [NUM_PORTS-1:0]   w_wr_en;
   logic                   w_complete;
   logic                   w_last;

   assign w_complete = (r_state == S_ISSUE) && ((w_pend & ~w_wr_en) == '0);
   assign w_last     = (r_tri_idx == r_num_tris - IDX_BITS'(1));

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      p_hit_dispatch_port u_port (
         .clock   (clock),
         .reset   (reset),
         .load    (tri_rd_en),
         .full    (in_full[k]),
         .wr_en   (w_wr_en[k]),
         .pending (w_pend[k])
      );
   end

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!ray_empty) w_next = (ray_num_tris == '0) ? S_DONE : S_FETCH;
         S_FETCH: if (!tri_empty) w_next = S_ISSUE;
         S_ISSUE: begin
            if (w_complete) begin
               if (w_last)
                  w_next = S_DONE;
               else if (tri_empty)
                  w_next = S_FETCH;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Pops are suppressed during reset so a queued ray or triangle is never lost
   always_comb begin
      ray_rd_en = (r_state == S_IDLE) && !ray_empty && !reset;
      tri_rd_en = (((r_state == S_FETCH) && !tri_empty) ||
                   (w_complete && !w_last && !tri_empty)) && !reset;
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_origin   <= '0;
         r_dir      <= '0;
         r_num_tris <= '0;
         r_normal   <= '0;
         r_v0       <= '0;
         r_tri_idx  <= '0;
      end else begin
         if (ray_rd_en) begin
            r_origin   <= ray_origin;
            r_dir      <= ray_dir;
            r_num_tris <= ray_num_tris;
         end
         if (tri_rd_en) begin
            r_normal <= tri_normal;
            r_v0     <= tri_v0;
         end
         if (r_state == S_DONE)
            r_tri_idx <= '0;
         else if (w_complete && !w_last)
            r_tri_idx <= r_tri_idx + IDX_BITS'(1);
      end
   end

`ifdef P_HIT_DISPATCH_STATS_EN
   logic [31:0] r_stall;

   always_ff @(posedge clock) begin
      if (reset)
         r_stall <= '0;
      else if ((r_state == S_ISSUE) && |(w_pend & in_full) && (r_stall != 32'hFFFF_FFFF))
         r_stall <= r_stall + 32'd1;
   end

   assign stall_cycles = r_stall;
`endif

   assign in_wr_en     = w_wr_en;
   assign tri_normal_1 = r_normal;
   assign tri_normal_2 = r_normal;
   assign v0           = r_v0;
   assign origin       = r_origin;
   assign dir          = r_dir;
   assign tri_idx      = r_tri_idx;
endmodule

// File: tb/tb_p_hit_dispatch.sv
// tb/tb_p_hit_dispatch.sv - scoreboard bench for p_hit_dispatch with FWFT FIFO models
module tb_p_hit_dispatch;
   typedef struct { logic [95:0] o; logic [95:0] d; logic [15:0] n; } ray_t;
   typedef struct { logic [95:0] nrm; logic [95:0] v; } tri_t;
   typedef struct { logic [95:0] nrm; logic [95:0] v; logic [95:0] o; logic [15:0] idx; } beat0_t;
   typedef struct { logic [95:0] nrm; logic [95:0] d; logic [15:0] idx; } beat1_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [95:0] ray_origin = '0, ray_dir = '0, tri_normal = '0, tri_v0 = '0;
   logic [15:0] ray_num_tris = '0;
   logic        ray_empty = 1'b1, tri_empty = 1'b1;
   logic        ray_rd_en, tri_rd_en, busy, done;
   logic [95:0] tri_normal_1, v0, origin, tri_normal_2, dir;
   logic [1:0]  in_wr_en;
   logic [1:0]  in_full = 2'b00;
   logic [15:0] tri_idx;
`ifdef P_HIT_DISPATCH_STATS_EN
   logic [31:0] stall_cycles;
`endif

   int n_tests = 0, n_fail = 0, cyc = 0;
   int n_done = 0, n_wr0 = 0, n_wr1 = 0, n_ray_pop = 0, n_tri_pop = 0;
   int last_ray_cyc = 0, last_done_cyc = 0;
   int wc0[$], wc1[$], tp[$];
   ray_t   ray_fifo[$];
   tri_t   tri_fifo[$];
   beat0_t exp0[$];
   beat1_t exp1[$];

   always #5 clock = ~clock;

   p_hit_dispatch dut (
      .clock(clock), .reset(reset),
      .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_num_tris(ray_num_tris),
      .ray_empty(ray_empty), .ray_rd_en(ray_rd_en),
      .tri_normal(tri_normal), .tri_v0(tri_v0), .tri_empty(tri_empty), .tri_rd_en(tri_rd_en),
      .tri_normal_1(tri_normal_1), .v0(v0), .origin(origin),
      .tri_normal_2(tri_normal_2), .dir(dir),
      .in_wr_en(in_wr_en), .in_full(in_full), .tri_idx(tri_idx),
      .busy(busy), .done(done)
`ifdef P_HIT_DISPATCH_STATS_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   function automatic logic [95:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic refresh();
      ray_empty = (ray_fifo.size() == 0);
      if (!ray_empty) begin
         ray_origin   = ray_fifo[0].o;
         ray_dir      = ray_fifo[0].d;
         ray_num_tris = ray_fifo[0].n;
      end
      tri_empty = (tri_fifo.size() == 0);
      if (!tri_empty) begin
         tri_normal = tri_fifo[0].nrm;
         tri_v0     = tri_fifo[0].v;
      end
   endtask

   task automatic push_ray(input logic [15:0] n, output ray_t r);
      r.o = rnd96(); r.d = rnd96(); r.n = n;
      ray_fifo.push_back(r);
      refresh();
   endtask

   // Pushes a triangle into the source FIFO and, when expected, its beat on both ports
   task automatic push_tri(input ray_t r, input logic [15:0] idx, input bit expect_beats, output tri_t t);
      beat0_t b0;
      beat1_t b1;
      t.nrm = rnd96(); t.v = rnd96();
      tri_fifo.push_back(t);
      if (expect_beats) begin
         b0.nrm = t.nrm; b0.v = t.v; b0.o = r.o; b0.idx = idx;
         b1.nrm = t.nrm; b1.d = r.d; b1.idx = idx;
         exp0.push_back(b0);
         exp1.push_back(b1);
      end
      refresh();
   endtask

   // Monitor: samples at the falling edge, applies FIFO pops just after the rising edge
   initial begin
      bit s_ray, s_tri;
      beat0_t e0;
      beat1_t e1;
      forever begin
         @(negedge clock);
         cyc++;
         s_ray = ray_rd_en;
         s_tri = tri_rd_en;
         n_tests++;
         if (s_ray && s_tri) begin
            n_fail++;
            $display("FAIL pop_exclusive: ray_rd_en=%b tri_rd_en=%b required not both", s_ray, s_tri);
         end
         n_tests++;
         if ((in_wr_en & in_full) !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_into_full: in_wr_en=%b in_full=%b", in_wr_en, in_full);
         end
         if (in_wr_en[0] === 1'b1) begin
            n_wr0++; wc0.push_back(cyc); n_tests++;
            if (exp0.size() == 0) begin
               n_fail++;
               $display("FAIL port0_spurious: write at cycle %0d with nothing expected", cyc);
            end else begin
               e0 = exp0.pop_front();
               if (tri_normal_1 !== e0.nrm || v0 !== e0.v || origin !== e0.o || tri_idx !== e0.idx) begin
                  n_fail++;
                  $display("FAIL port0_beat: got nrm=%h v0=%h org=%h idx=%0d required nrm=%h v0=%h org=%h idx=%0d",
                           tri_normal_1, v0, origin, tri_idx, e0.nrm, e0.v, e0.o, e0.idx);
               end
            end
         end
         if (in_wr_en[1] === 1'b1) begin
            n_wr1++; wc1.push_back(cyc); n_tests++;
            if (exp1.size() == 0) begin
               n_fail++;
               $display("FAIL port1_spurious: write at cycle %0d with nothing expected", cyc);
            end else begin
               e1 = exp1.pop_front();
               if (tri_normal_2 !== e1.nrm || dir !== e1.d || tri_idx !== e1.idx) begin
                  n_fail++;
                  $display("FAIL port1_beat: got nrm=%h dir=%h idx=%0d required nrm=%h dir=%h idx=%0d",
                           tri_normal_2, dir, tri_idx, e1.nrm, e1.d, e1.idx);
               end
            end
         end
         if (s_ray) begin n_ray_pop++; last_ray_cyc = cyc; end
         if (s_tri) begin n_tri_pop++; tp.push_back(cyc); end
         if (done === 1'b1) begin n_done++; last_done_cyc = cyc; end
         @(posedge clock);
         #1;
         if (s_ray && ray_fifo.size() > 0) void'(ray_fifo.pop_front());
         if (s_tri && tri_fifo.size() > 0) void'(tri_fifo.pop_front());
         refresh();
      end
   end

   task automatic wait_done(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #1;
         if (n_done > base) begin ok = 1'b1; break; end
      end
   endtask

   task automatic step();
      @(posedge clock); #2;
   endtask

   task automatic test_reset();
      repeat (2) step();
      reset = 1'b0;
      @(negedge clock); #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || in_wr_en !== 2'b00 || ray_rd_en !== 1'b0 || tri_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy=%b done=%b wr=%b rrd=%b trd=%b required all 0",
                  busy, done, in_wr_en, ray_rd_en, tri_rd_en);
      end
      n_tests++;
      if (tri_idx !== 16'd0 || tri_normal_1 !== '0 || tri_normal_2 !== '0 || v0 !== '0 || origin !== '0 || dir !== '0) begin
         n_fail++;
         $display("FAIL reset_data: idx=%0d nrm1=%h v0=%h org=%h required 0", tri_idx, tri_normal_1, v0, origin);
      end
`ifdef P_HIT_DISPATCH_STATS_EN
      n_tests++;
      if (stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_stall: stall_cycles=%0d required 0", stall_cycles);
      end
`endif
   endtask

   task automatic test_back_to_back();
      ray_t r; tri_t t; bit ok; int d0, w0, w1, b;
      step();
      d0 = n_done; w0 = n_wr0; w1 = n_wr1; b = wc0.size();
      push_ray(16'd3, r);
      for (int i = 0; i < 3; i++) push_tri(r, 16'(i), 1'b1, t);
      wait_done(d0, 40, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL b2b_timeout: done not seen within 40 cycles"); end
      n_tests++;
      if (n_wr0 - w0 != 3 || n_wr1 - w1 != 3) begin
         n_fail++;
         $display("FAIL b2b_count: port0=%0d port1=%0d required 3 each", n_wr0 - w0, n_wr1 - w1);
      end
      n_tests++;
      if (wc0.size() >= b + 3 && wc0[b + 2] - wc0[b] != 2) begin
         n_fail++;
         $display("FAIL b2b_spacing: beats span %0d cycles required 2", wc0[b + 2] - wc0[b]);
      end
      @(negedge clock); #1;
      n_tests++;
      if (busy !== 1'b0 || n_done - d0 != 1 || tri_idx !== 16'd0) begin
         n_fail++;
         $display("FAIL b2b_end: busy=%b dones=%0d idx=%0d required 0,1,0", busy, n_done - d0, tri_idx);
      end
   endtask

   task automatic test_zero_tris();
      ray_t r; bit ok; int d0, tp0, w0, rp0;
      step();
      d0 = n_done; tp0 = n_tri_pop; w0 = n_wr0 + n_wr1; rp0 = n_ray_pop;
      push_ray(16'd0, r);
      wait_done(d0, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL zero_timeout: done not seen within 20 cycles"); end
      n_tests++;
      if (n_ray_pop - rp0 != 1 || n_tri_pop != tp0 || n_wr0 + n_wr1 != w0) begin
         n_fail++;
         $display("FAIL zero_activity: ray_pops=%0d tri_pops=%0d writes=%0d required 1,0,0",
                  n_ray_pop - rp0, n_tri_pop - tp0, n_wr0 + n_wr1 - w0);
      end
      n_tests++;
      if (last_done_cyc - last_ray_cyc != 1) begin
         n_fail++;
         $display("FAIL zero_latency: done %0d cycles after pop required 1", last_done_cyc - last_ray_cyc);
      end
   endtask

   task automatic test_port_full();
      ray_t r; tri_t t; bit ok; int d0, w0, w1, b0, b1, bt;
      step();
      in_full = 2'b01;
      d0 = n_done; w0 = n_wr0; w1 = n_wr1; b0 = wc0.size(); b1 = wc1.size(); bt = tp.size();
      push_ray(16'd2, r);
      push_tri(r, 16'd0, 1'b1, t);
      push_tri(r, 16'd1, 1'b1, t);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (n_wr1 > w1) begin ok = 1'b1; break; end
      end
      n_tests++;
      if (!ok || n_wr0 != w0) begin
         n_fail++;
         $display("FAIL full_port1_first: port1 seen=%b port0 writes=%0d required 1,0", ok, n_wr0 - w0);
      end
      repeat (4) @(posedge clock);
      #2 in_full = 2'b00;
      wait_done(d0, 30, ok);
      n_tests++;
      if (!ok || n_wr0 - w0 != 2 || n_wr1 - w1 != 2) begin
         n_fail++;
         $display("FAIL full_count: done=%b port0=%0d port1=%0d required 1,2,2", ok, n_wr0 - w0, n_wr1 - w1);
      end
      n_tests++;
      if (wc0.size() < b0 + 1 || wc1.size() < b1 + 1 || wc0[b0] - wc1[b1] != 4) begin
         n_fail++;
         $display("FAIL full_delay: port0 beat0 lag not 4 cycles (wr0 entries=%0d)", wc0.size() - b0);
      end else begin
         n_tests++;
         if (tp.size() < bt + 2 || tp[bt + 1] < wc0[b0]) begin
            n_fail++;
            $display("FAIL full_early_pop: tri pops=%0d second pop precedes port0 write at %0d",
                     tp.size() - bt, wc0[b0]);
         end
      end
   endtask

   task automatic test_tri_empty();
      ray_t r; tri_t t0, t1; bit ok; int d0, w0, w1;
      step();
      d0 = n_done; w0 = n_wr0; w1 = n_wr1;
      push_ray(16'd2, r);
      push_tri(r, 16'd0, 1'b1, t0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (n_wr0 > w0) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clock);
      #1;
      n_tests++;
      if (!ok || busy !== 1'b1 || n_wr0 - w0 != 1 || n_wr1 - w1 != 1 || tri_normal_1 !== t0.nrm || v0 !== t0.v) begin
         n_fail++;
         $display("FAIL empty_hold: busy=%b wr0=%0d wr1=%0d nrm=%h required 1,1,1,%h",
                  busy, n_wr0 - w0, n_wr1 - w1, tri_normal_1, t0.nrm);
      end
      step();
      push_tri(r, 16'd1, 1'b1, t1);
      wait_done(d0, 20, ok);
      n_tests++;
      if (!ok || n_wr0 - w0 != 2 || n_wr1 - w1 != 2) begin
         n_fail++;
         $display("FAIL empty_finish: done=%b port0=%0d port1=%0d required 1,2,2", ok, n_wr0 - w0, n_wr1 - w1);
      end
   endtask

   task automatic test_mid_reset();
      ray_t r; tri_t t; bit ok; int tp0, d0, w0, w1;
      step();
      in_full = 2'b11;
      tp0 = n_tri_pop;
      push_ray(16'd2, r);
      push_tri(r, 16'd0, 1'b0, t);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (n_tri_pop > tp0) begin ok = 1'b1; break; end
      end
      repeat (2) step();
      reset = 1'b1;
      in_full = 2'b00;
      @(negedge clock); #1;
      n_tests++;
      if (!ok || in_wr_en !== 2'b00 || ray_rd_en !== 1'b0 || tri_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_strobe: fetched=%b wr=%b rrd=%b trd=%b required 1,00,0,0",
                  ok, in_wr_en, ray_rd_en, tri_rd_en);
      end
      step();
      reset = 1'b0;
      @(negedge clock); #1;
      n_tests++;
      if (in_wr_en !== 2'b00 || busy !== 1'b0 || tri_idx !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset_state: wr=%b busy=%b idx=%0d required 00,0,0", in_wr_en, busy, tri_idx);
      end
      step();
      d0 = n_done; w0 = n_wr0; w1 = n_wr1;
      push_ray(16'd1, r);
      push_tri(r, 16'd0, 1'b1, t);
      wait_done(d0, 20, ok);
      n_tests++;
      if (!ok || n_wr0 - w0 != 1 || n_wr1 - w1 != 1 || exp0.size() != 0 || exp1.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_recover: done=%b port0=%0d port1=%0d left=%0d/%0d required 1,1,1,0/0",
                  ok, n_wr0 - w0, n_wr1 - w1, exp0.size(), exp1.size());
      end
   endtask

`ifdef P_HIT_DISPATCH_STATS_EN
   task automatic test_stats();
      ray_t r; tri_t t; bit ok; int tp0, d0;
      step();
      n_tests++;
      if (stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL stats_start: stall_cycles=%0d required 0", stall_cycles);
      end
      in_full = 2'b11;
      tp0 = n_tri_pop; d0 = n_done;
      push_ray(16'd1, r);
      push_tri(r, 16'd0, 1'b1, t);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (n_tri_pop > tp0) begin ok = 1'b1; break; end
      end
      repeat (6) @(posedge clock);
      #2 in_full = 2'b00;
      wait_done(d0, 20, ok);
      n_tests++;
      if (!ok || stall_cycles !== 32'd5) begin
         n_fail++;
         $display("FAIL stats_count: done=%b stall_cycles=%0d required 1,5", ok, stall_cycles);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_zero_tris();
      test_port_full();
      test_tri_empty();
      test_mid_reset();
`ifdef P_HIT_DISPATCH_STATS_EN
      test_stats();
`endif
      repeat (3) step();
      n_tests++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_beats: port0=%0d port1=%0d required 0", exp0.size(), exp1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
